// File: rtl/array_result_streamer.sv
// array_result_streamer
// Sits behind the single-cycle bubble-sort processor. It detects the branch-to-self halt loop
// (PC_out unchanged for STABLE_CYCLES consecutive cycles) or an explicit start pulse. It then
// snapshots array0..array6, checks that the snapshot is non-decreasing, and streams the seven
// words over a valid/ready port. It also reports the cycle count from reset release to halt.
//
// Optional build macro ARRAY_STREAM_CYCLES_EN: appends an eighth beat carrying cycle_count
// (zero-extended or truncated to 32 bits). That beat carries out_last.
//
// Ports:
//   clk, reset         clock; asynchronous active-low reset
//   PC_out             processor program counter, watched for the halt loop
//   array0..array6     data-memory array words, snapshotted on capture
//   start              single-cycle pulse forcing a capture (from IDLE or DONE)
//   out_data/out_valid/out_ready/out_last   result stream
//   sorted             snapshot is non-decreasing (signed or unsigned per SIGNED_CMP)
//   busy               capture or stream in progress
//   done               a dump has completed since reset
//   cycle_count        cycles spent in IDLE since reset release, saturating
module array_result_streamer #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 32,
  parameter int unsigned SIGNED_CMP    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [63:0]      PC_out,
  input  logic [31:0]      array0,
  input  logic [31:0]      array1,
  input  logic [31:0]      array2,
  input  logic [31:0]      array3,
  input  logic [31:0]      array4,
  input  logic [31:0]      array5,
  input  logic [31:0]      array6,
  input  logic             start,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             sorted,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

`ifdef ARRAY_STREAM_CYCLES_EN
  localparam logic [2:0] LastIdx = 3'd7;
`else
  localparam logic [2:0] LastIdx = 3'd6;
`endif
  localparam logic [7:0] StableMax = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {StIdle, StCapture, StSend, StDone} state_e;

  state_e           state_q;
  logic [63:0]      prev_pc_q;
  logic [7:0]       stable_cnt_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [2:0]       idx_q;
  logic [31:0]      snap_q [7];
  logic [31:0]      out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic             sorted_q;
  logic             busy_q;
  logic             done_q;

  logic [31:0]      arr_in [7];
  logic [31:0]      words [8];
  logic             pc_same;
  logic             halt_hit;
  logic             sorted_d;
  logic [2:0]       idx_d;

  always_comb begin
    arr_in[0] = array0;
    arr_in[1] = array1;
    arr_in[2] = array2;
    arr_in[3] = array3;
    arr_in[4] = array4;
    arr_in[5] = array5;
    arr_in[6] = array6;
  end

  assign pc_same  = (PC_out == prev_pc_q);
  // This cycle is the STABLE_CYCLES-th consecutive cycle with an unchanged PC.
  assign halt_hit = pc_same && (stable_cnt_q == StableMax - 8'd1);
  assign idx_d    = idx_q + 3'd1;

`ifdef ARRAY_STREAM_CYCLES_EN
  logic [31:0] cyc32;
  if (CNT_W >= 32) begin : g_cyc_trunc
    assign cyc32 = cycle_count_q[31:0];
  end else begin : g_cyc_ext
    assign cyc32 = {{(32 - CNT_W){1'b0}}, cycle_count_q};
  end
`endif

  // Beat payloads; entry 7 is only reachable when the cycle-count beat is built in.
  always_comb begin
    for (int i = 0; i < 7; i++) words[i] = snap_q[i];
`ifdef ARRAY_STREAM_CYCLES_EN
    words[7] = cyc32;
`else
    words[7] = 32'd0;
`endif
  end

  function automatic logic in_order(logic [31:0] a, logic [31:0] b);
    if (SIGNED_CMP != 0) return $signed(a) <= $signed(b);
    return a <= b;
  endfunction

  always_comb begin
    sorted_d = 1'b1;
    for (int i = 0; i < 6; i++) sorted_d = sorted_d & in_order(snap_q[i], snap_q[i+1]);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      prev_pc_q     <= '0;
      stable_cnt_q  <= '0;
      cycle_count_q <= '0;
      idx_q         <= '0;
      for (int i = 0; i < 7; i++) snap_q[i] <= '0;
      out_data_q    <= '0;
      out_valid_q   <= 1'b0;
      out_last_q    <= 1'b0;
      sorted_q      <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          prev_pc_q <= PC_out;
          if (!pc_same)                      stable_cnt_q <= '0;
          else if (stable_cnt_q < StableMax) stable_cnt_q <= stable_cnt_q + 8'd1;
          if (cycle_count_q != {CNT_W{1'b1}}) begin
            cycle_count_q <= cycle_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
          end
          if (start || halt_hit) begin
            state_q <= StCapture;
            snap_q  <= arr_in;
            busy_q  <= 1'b1;
          end
        end
        StCapture: begin
          sorted_q    <= sorted_d;
          idx_q       <= '0;
          out_data_q  <= words[0];
          out_last_q  <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= StSend;
        end
        StSend: begin
          if (out_valid_q && out_ready) begin
            if (idx_q == LastIdx) begin
              state_q     <= StDone;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              out_data_q  <= '0;
              busy_q      <= 1'b0;
              done_q      <= 1'b1;
            end else begin
              idx_q      <= idx_d;
              out_data_q <= words[idx_d];
              out_last_q <= (idx_d == LastIdx);
            end
          end
        end
        StDone: begin
          // Re-arm keeps done and cycle_count; only the snapshot is refreshed.
          if (start) begin
            state_q <= StCapture;
            snap_q  <= arr_in;
            busy_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_last    = out_last_q;
  assign sorted      = sorted_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_array_result_streamer.sv
// Randomized scoreboard bench for array_result_streamer. Expected beats are queued when a
// capture is triggered; a forked monitor pops and compares on every accepted beat and checks
// that data/last hold while stalled. A second instance built with SIGNED_CMP=0 is used only
// for its sorted flag.
module tb_array_result_streamer;
  localparam int unsigned StableCycles = 4;
  localparam int unsigned CntW = 32;
`ifdef ARRAY_STREAM_CYCLES_EN
  localparam int NumBeats = 8;
`else
  localparam int NumBeats = 7;
`endif

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     pc;
  logic [31:0]     arr [7];
  logic            start;
  logic            out_ready;
  logic [31:0]     out_data, out_data_u;
  logic            out_valid, out_valid_u, out_last, out_last_u;
  logic            sorted, sorted_u, busy, busy_u, done, done_u;
  logic [CntW-1:0] cycle_count, cycle_count_u;

  int          checks = 0;
  int          errors = 0;
  beat_t       exp_q[$];
  logic [31:0] exp_snap [7];
  logic [31:0] exp_cyc;
  int          pcs [64];

  always #5 clk = ~clk;

  array_result_streamer #(.STABLE_CYCLES(StableCycles), .CNT_W(CntW), .SIGNED_CMP(1)) dut (
    .clk(clk), .reset(reset), .PC_out(pc),
    .array0(arr[0]), .array1(arr[1]), .array2(arr[2]), .array3(arr[3]),
    .array4(arr[4]), .array5(arr[5]), .array6(arr[6]),
    .start(start), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .sorted(sorted), .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  array_result_streamer #(.STABLE_CYCLES(StableCycles), .CNT_W(CntW), .SIGNED_CMP(0)) dut_u (
    .clk(clk), .reset(reset), .PC_out(pc),
    .array0(arr[0]), .array1(arr[1]), .array2(arr[2]), .array3(arr[3]),
    .array4(arr[4]), .array5(arr[5]), .array6(arr[6]),
    .start(start), .out_data(out_data_u), .out_valid(out_valid_u), .out_ready(out_ready),
    .out_last(out_last_u), .sorted(sorted_u), .busy(busy_u), .done(done_u),
    .cycle_count(cycle_count_u)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-decreasing check over the captured words, straight from the definition.
  function automatic bit model_sorted(input bit signed_cmp);
    for (int i = 0; i < 6; i++) begin
      if (signed_cmp) begin
        if ($signed(exp_snap[i]) > $signed(exp_snap[i+1])) return 1'b0;
      end else if (exp_snap[i] > exp_snap[i+1]) begin
        return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // First edge at which PC has equalled its predecessor StableCycles times in a row.
  function automatic int model_halt_edge();
    int run = 0;
    for (int e = 1; e < 64; e++) begin
      run = (pcs[e] == pcs[e-1]) ? run + 1 : 0;
      if (run == StableCycles) return e;
    end
    return -1;
  endfunction

  task automatic push_dump();
    for (int i = 0; i < 7; i++) exp_q.push_back('{data: exp_snap[i], last: (i == NumBeats - 1)});
`ifdef ARRAY_STREAM_CYCLES_EN
    exp_q.push_back('{data: exp_cyc, last: 1'b1});
`endif
  endtask

  task automatic monitor();
    logic [31:0] hold_d;
    logic        hold_l;
    bit          stalled;
    beat_t       b;
    stalled = 0;
    hold_d  = '0;
    hold_l  = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset || !out_valid) begin
        stalled = 0;
      end else begin
        if (stalled) begin
          check("stall_hold_data", out_data, hold_d);
          check("stall_hold_last", out_last, hold_l);
        end
        if (out_ready) begin
          stalled = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data 0x%0h with no beat expected", out_data);
          end else begin
            b = exp_q.pop_front();
            check("beat_data", out_data, b.data);
            check("beat_last", out_last, b.last);
          end
        end else begin
          stalled = 1;
          hold_d  = out_data;
          hold_l  = out_last;
        end
      end
    end
  endtask

  task automatic set_arr(input int v0, v1, v2, v3, v4, v5, v6);
    int v[7];
    v = '{v0, v1, v2, v3, v4, v5, v6};
    for (int i = 0; i < 7; i++) arr[i] = v[i];
  endtask

  task automatic rand_arr();
    if ($urandom_range(0, 1) == 1) begin
      arr[0] = $urandom;
      arr[0] = {arr[0][31], arr[0][31], arr[0][29:0]};
      for (int i = 1; i < 7; i++) arr[i] = arr[i-1] + $urandom_range(0, 3);
    end else begin
      for (int i = 0; i < 7; i++) arr[i] = $urandom;
    end
  endtask

  // Capture via start (from IDLE or DONE) and stream to completion.
  task automatic run_dump(input bit rnd_ready, input bit scramble, input bit poke_start);
    int n;
    exp_snap = arr;
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("valid_in_capture", out_valid, 0);
    tick();
    check("valid_after_capture", out_valid, 1);
    check("sorted_signed", sorted, model_sorted(1'b1));
    check("sorted_unsigned", sorted_u, model_sorted(1'b0));
    n = 0;
    while (busy && n < 200) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (scramble) for (int i = 0; i < 7; i++) arr[i] = $urandom;
      if (poke_start) start = ($urandom_range(0, 3) == 0);
      tick();
      n++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    if (busy) begin
      checks++;
      errors++;
      $display("FAIL dump_timeout: busy still 1 after %0d cycles, required 0", n);
    end
    check("done_after_dump", done, 1);
    check("done_u_after_dump", done_u, 1);
    check("queue_drained", exp_q.size(), 0);
    check("cycle_count_held", cycle_count, exp_cyc);
    repeat (3) tick();
    check("no_extra_valid", out_valid, 0);
  endtask

  initial begin
    int j, e, v, n;
    fork
      monitor();
    join_none
    reset = 1'b0;
    pc = '0;
    start = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) arr[i] = '0;
    repeat (3) tick();
    check("rst_out_data", out_data, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sorted", sorted, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cycle_count", cycle_count, 0);

    // Halt detection: PC walks in steps of 4 with short holds, then parks.
    pcs[0] = 0;
    e = 1;
    v = 0;
    while (e <= 32) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n && e <= 32; k++) begin
        pcs[e] = v;
        e++;
      end
      v += 4;
    end
    for (; e < 64; e++) pcs[e] = 32'h1000;
    j = model_halt_edge();
    set_arr(1, 2, 3, 4, 5, 6, 7);
    exp_snap = arr;
    exp_cyc = 32'(j);
    push_dump();
    reset = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      pc = 64'(pcs[k]);
      tick();
      if (k <= j + 1) begin
        check("halt_busy", busy, (k >= j));
        check("halt_valid", out_valid, (k >= j + 1));
      end
    end
    n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("halt_done", done, 1);
    check("halt_sorted", sorted, model_sorted(1'b1));
    check("halt_sorted_u", sorted_u, model_sorted(1'b0));
    check("halt_cycle_count", cycle_count, exp_cyc);
    check("halt_queue_drained", exp_q.size(), 0);

    // Sortedness edge cases, backpressure with array churn, re-arm with start during SEND.
    set_arr(-5, 3, 3, 0, 9, 10, 12);
    run_dump(1'b0, 1'b0, 1'b0);
    set_arr(-5, -1, 0, 0, 2, 8, 9);
    run_dump(1'b1, 1'b1, 1'b0);
    set_arr(7, 6, 5, 4, 3, 2, 1);
    run_dump(1'b1, 1'b0, 1'b1);
    repeat (4) begin
      rand_arr();
      run_dump(1'b1, 1'b1, 1'b1);
    end

    // Reset in the middle of a stream.
    rand_arr();
    exp_snap = arr;
    push_dump();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (exp_q.size() > NumBeats - 3 && n < 100) begin
      tick();
      n++;
    end
    #1 reset = 1'b0;
    #1;
    exp_q.delete();
    check("midrst_out_data", out_data, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_last", out_last, 0);
    check("midrst_sorted", sorted, 0);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_cycle_count", cycle_count, 0);
    repeat (2) tick();
    reset = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      pc = 64'h2000 + 64'(4 * k);
      tick();
      check("restart_cycle_count", cycle_count, k);
      check("restart_busy", busy, 0);
      check("restart_done", done, 0);
    end
    exp_cyc = 32'd6;
    rand_arr();
    run_dump(1'b1, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
